anc_gain_stage: RTL and testbench

//   Pipelined, multi-channel signed gain stage for the ANC datapath. Successor to the fixed
//   16-bit negator: each sample is scaled by a programmable per-channel Qm.FRAC_W coefficient
//   (reset default -1.0, i.e. plain inversion), then rounded and saturated.

---
 rtl/anc_gain_stage.sv | 191 +++++++++++++++++++
 tb/tb_anc_gain_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/anc_gain_stage.sv
// Per-channel signed gain stage: Q(COEF_W-FRAC_W).FRAC_W coefficient, round half up and saturate; 3-cycle latency, 1 sample/cycle.
// Backpressure: a stalled output freezes every stage and drops in_ready_o; optional ANC_GAIN_SATCNT_EN adds a clip counter.
module anc_gain_stage #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 14,
  parameter int NCH    = 2,
  parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CH_W-1:0]   in_ch_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CH_W-1:0]   out_ch_o,
  output logic              out_sat_o,
  input  logic              coef_we_i,
  input  logic [CH_W-1:0]   coef_addr_i,
  input  logic [COEF_W-1:0] coef_data_i,
  input  logic              coef_commit_i
`ifdef ANC_GAIN_SATCNT_EN
  ,
  input  logic              sat_clr_i,
  output logic [15:0]       sat_count_o
`endif
);

  localparam int PW = DATA_W + COEF_W;
  localparam logic [CH_W:0] NCH_V = (CH_W+1)'(NCH);
  localparam logic signed [COEF_W-1:0] COEF_RST = COEF_W'(-(1 << FRAC_W));
  localparam logic signed [PW-1:0] RND = {{(PW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef struct packed {
    logic              vld;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] dat;
    logic [COEF_W-1:0] coef;
  } s1_t;

  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
    logic [PW-1:0]   prod;
  } s2_t;

  logic [COEF_W-1:0] shadow_q [NCH];
  logic [COEF_W-1:0] shadow_d [NCH];
  logic [COEF_W-1:0] active_q [NCH];
  logic [COEF_W-1:0] active_d [NCH];

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_dat_q, out_dat_d;
  logic [CH_W-1:0]   out_ch_q,  out_ch_d;
  logic              out_sat_q, out_sat_d;

  logic              stall;
  logic              ch_ok;
  logic [COEF_W-1:0] sel_coef;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rnd_sum;
  logic signed [PW-1:0] rnd_shr;
  logic              clip_hi;
  logic              clip_lo;
  logic [DATA_W-1:0] sat_dat;

  // A write in the commit cycle lands in shadow_d, so the commit picks it up.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (coef_we_i && ({1'b0, coef_addr_i} == (CH_W+1)'(i))) begin
        shadow_d[i] = coef_data_i;
      end
      active_d[i] = coef_commit_i ? shadow_d[i] : active_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= COEF_RST;
        active_q[i] <= COEF_RST;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign stall      = out_vld_q && !out_ready_i;
  assign in_ready_o = !stall;

  // Unknown channel tags still flow through, scaled by zero.
  assign ch_ok    = ({1'b0, in_ch_i} < NCH_V);
  assign sel_coef = ch_ok ? active_q[in_ch_i] : '0;

  assign prod = $signed({{COEF_W{s1_q.dat[DATA_W-1]}}, s1_q.dat}) *
                $signed({{DATA_W{s1_q.coef[COEF_W-1]}}, s1_q.coef});

  assign rnd_sum = $signed(s2_q.prod) + RND;
  assign rnd_shr = rnd_sum >>> FRAC_W;
  assign clip_hi = rnd_shr > SAT_MAX;
  assign clip_lo = rnd_shr < SAT_MIN;
  assign sat_dat = clip_hi ? SAT_MAX[DATA_W-1:0] :
                   clip_lo ? SAT_MIN[DATA_W-1:0] : rnd_shr[DATA_W-1:0];

  always_comb begin
    s1_d      = s1_q;
    s2_d      = s2_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_ch_d  = out_ch_q;
    out_sat_d = out_sat_q;
    if (!stall) begin
      s1_d.vld = in_valid_i;
      if (in_valid_i) begin
        s1_d.ch   = in_ch_i;
        s1_d.dat  = in_data_i;
        s1_d.coef = sel_coef;
      end
      s2_d.vld = s1_q.vld;
      if (s1_q.vld) begin
        s2_d.ch   = s1_q.ch;
        s2_d.prod = prod;
      end
      out_vld_d = s2_q.vld;
      if (s2_q.vld) begin
        out_dat_d = sat_dat;
        out_ch_d  = s2_q.ch;
        out_sat_d = clip_hi || clip_lo;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q      <= '0;
      s2_q      <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_ch_q  <= '0;
      out_sat_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_ch_q  <= out_ch_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign out_valid_o = out_vld_q;
  assign out_data_o  = out_dat_q;
  assign out_ch_o    = out_ch_q;
  assign out_sat_o   = out_sat_q;

`ifdef ANC_GAIN_SATCNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr_i) begin
      sat_cnt_d = '0;
    end else if (out_vld_q && out_ready_i && out_sat_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_count_o = sat_cnt_q;
`endif

endmodule

// File: tb/tb_anc_gain_stage.sv
// Directed bench for anc_gain_stage: vector table plus hand sequences for commit, stall, reset and clip counting.
module tb_anc_gain_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic signed [15:0] in_data, out_data;
  logic [0:0]         in_ch, out_ch, coef_addr;
  logic [15:0]        coef_data;
  logic               coef_we, coef_commit;
`ifdef ANC_GAIN_SATCNT_EN
  logic               sat_clr;
  logic [15:0]        sat_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  anc_gain_stage dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_ch_i(in_ch),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_ch_o(out_ch), .out_sat_o(out_sat),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
    .coef_commit_i(coef_commit)
`ifdef ANC_GAIN_SATCNT_EN
    , .sat_clr_i(sat_clr), .sat_count_o(sat_count)
`endif
  );

  typedef struct {
    logic [0:0]         ch;
    logic signed [15:0] din;
    logic signed [15:0] dout;
    logic               sat;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One isolated sample with out_ready high; checks latency, data, sat flag and tag.
  task automatic send_one(input string name, input logic [0:0] ch, input logic signed [15:0] din,
                          input logic signed [15:0] dout, input logic sat);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_ch = ch; in_data = din;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 8);
    check({name, " latency"}, lat, 3);
    check({name, " data"}, out_data, dout);
    check({name, " sat"}, out_sat, sat);
    check({name, " ch"}, out_ch, ch);
  endtask

  task automatic stream_test();
    int sent, recv, cyc;
    logic held;
    logic signed [15:0] hd;
    logic [0:0] hc;
    logic signed [31:0] exp;
    sent = 0; recv = 0; cyc = 0; held = 1'b0; hd = '0; hc = '0;
    while (recv < 20 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        check("stall hold valid", out_valid, 1);
        check("stall hold data", out_data, hd);
        check("stall hold ch", out_ch, hc);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = (sent < 20);
      in_data   = 16'(sent);
      in_ch     = 1'(sent);
      #1;
      if (in_valid && in_ready) sent++;
      held = out_valid && !out_ready;
      hd = out_data;
      hc = out_ch;
      if (out_valid && out_ready) begin
        exp = (recv % 2 == 0) ? -recv : (recv + 1) / 2;
        check($sformatf("stream[%0d] data", recv), out_data, exp);
        check($sformatf("stream[%0d] ch", recv), out_ch, recv % 2);
        recv++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream count", recv, 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Default coefficient -1.0 (-16384): plain negation with rounding half up.
    vt[0]  = '{1'b0, 16'sd1000,   -16'sd1000,  1'b0};
    vt[1]  = '{1'b0, 16'sh8000,   16'sd32767,  1'b1};
    vt[2]  = '{1'b0, 16'sd32767,  -16'sd32767, 1'b0};
    vt[3]  = '{1'b1, 16'sh8000,   16'sd32767,  1'b1};
    vt[4]  = '{1'b1, 16'sd0,      16'sd0,      1'b0};
    vt[5]  = '{1'b0, -16'sd1,     16'sd1,      1'b0};
    // ch1 at 0.5 (8192), ch0 still -1.0.
    vt[6]  = '{1'b1, 16'sd3,      16'sd2,      1'b0};
    vt[7]  = '{1'b1, -16'sd3,     -16'sd1,     1'b0};
    vt[8]  = '{1'b0, 16'sd7,      -16'sd7,     1'b0};
    vt[9]  = '{1'b1, 16'sh8000,   -16'sd16384, 1'b0};
    vt[10] = '{1'b1, 16'sd32767,  16'sd16384,  1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ch = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
`ifdef ANC_GAIN_SATCNT_EN
    sat_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_ch", out_ch, 0);
    check("reset out_sat", out_sat, 0);
    check("reset in_ready", in_ready, 1);
`ifdef ANC_GAIN_SATCNT_EN
    check("reset sat_count", sat_count, 0);
`endif

    for (int i = 0; i < 6; i++) send_one($sformatf("vec%0d", i), vt[i].ch, vt[i].din, vt[i].dout, vt[i].sat);

    // Write+commit in one cycle alongside a ch1 sample: that sample uses the old coefficient.
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 1'b1; coef_data = 16'd8192; coef_commit = 1'b1;
    in_valid = 1'b1; in_ch = 1'b1; in_data = 16'sd3;
    @(negedge clk);
    coef_we = 1'b0; coef_commit = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("commit-cycle valid", out_valid, 1);
    check("commit-cycle old coef", out_data, -3);
    @(negedge clk);
    check("post-commit valid", out_valid, 1);
    check("post-commit new coef", out_data, 2);

    for (int i = 6; i < 11; i++) send_one($sformatf("vec%0d", i), vt[i].ch, vt[i].din, vt[i].dout, vt[i].sat);

    stream_test();

    // Shadow write alone must not change the active coefficient.
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 1'b0; coef_data = 16'd16384;
    @(negedge clk);
    coef_we = 1'b0;
    send_one("shadow only", 1'b0, 16'sd5, -16'sd5, 1'b0);
    @(negedge clk);
    coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0;
    send_one("after commit ch0", 1'b0, 16'sd5, 16'sd5, 1'b0);
    send_one("after commit ch1", 1'b1, 16'sd5, 16'sd3, 1'b0);

    // Fill the pipeline against a stalled output, then reset.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_ch = 1'b0; in_data = 16'sd100;
    @(negedge clk);
    in_data = 16'sd200;
    @(negedge clk);
    in_data = 16'sd300;
    @(negedge clk);
    in_valid = 1'b0;
    check("prefill out_valid", out_valid, 1);
    check("prefill out_data", out_data, 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    check("midrst out_valid", out_valid, 0);
    check("midrst out_data", out_data, 0);
    check("midrst out_ch", out_ch, 0);
    repeat (3) @(negedge clk);
    check("midrst no stale output", out_valid, 0);
    send_one("midrst coef ch0", 1'b0, 16'sd1000, -16'sd1000, 1'b0);
    send_one("midrst coef ch1", 1'b1, 16'sd1000, -16'sd1000, 1'b0);

`ifdef ANC_GAIN_SATCNT_EN
    check("satcnt after reset", sat_count, 0);
    @(negedge clk);
    in_valid = 1'b1; in_ch = 1'b0; in_data = 16'sh8000;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("satcnt five clips", sat_count, 5);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("clr beat out_sat", out_sat, 1);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    check("satcnt clear wins", sat_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
